cpc_audio_mixer: RTL and testbench
==================================

# cpc_audio_mixer

Parametrised, time-multiplexed stereo mixer that replaces the fixed three-channel PSG sum feeding `audio_l`/`audio_r` on the motherboard. It supports N input channels, for example the three PSG channels plus Plus-mode DMA or expansion sources, each with an independent 2-bit left and right gain code. On each sample strobe it snapshots all channels and accumulates one channel per clock. It then saturates the result and presents registered stereo outputs with a one-cycle valid pulse.

## Interface
Parameters:
- `NUM_CH`, default 3, number of input channels (1..8).
- `IN_W`, default 8, unsigned channel sample width.
- `OUT_W`, default 8, output sample width (≥ IN_W).

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `ce`  in  1  sample strobe, one clk wide, typically `cclk_en_p`.
- `ch_in`  in  NUM_CH*IN_W  channel samples; channel k at `[k*IN_W +: IN_W]`.
- `pan_l`  in  NUM_CH*2  left gain codes; channel k at `[2k +: 2]`.
- `pan_r`  in  NUM_CH*2  right gain codes, same packing.
- `audio_l`  out  OUT_W  mixed left sample, registered.
- `audio_r`  out  OUT_W  mixed right sample, registered.
- `out_valid`  out  1  one-cycle pulse when `audio_l`/`audio_r` update.
- `busy`  out  1  high while a mix is in progress.
- `overrun`  out  1  sticky; set when a `ce` is dropped.

## Operation
- Gain code mapping: 3 gives x, 2 gives x>>1, 1 gives x>>2, 0 gives 0 (muted).
- The legacy mix is pan_l = {C:0, B:1, A:2} and pan_r = {C:2, B:1, A:0}.
- Accumulators are unsigned, IN_W + clog2(NUM_CH) + 1 bits wide, so they never wrap internally.
- FSM states: IDLE, ACC, OUT.
  - IDLE: when `ce`=1, latch `ch_in`, `pan_l` and `pan_r` into snapshot registers, clear both accumulators, set idx=0, and go to ACC.
  - ACC: each clk, add the scaled channel idx to acc_l and acc_r, then increment idx. After channel NUM_CH-1 is added, go to OUT.
  - OUT: saturate each accumulator to 2^OUT_W-1, write `audio_l`/`audio_r`, and pulse `out_valid`=1. If `ce`=1 in this state, behave as IDLE with `ce` (snapshot again, go to ACC). Otherwise go to IDLE.
- Inputs may change freely once snapshotted. A pan change takes effect at the next snapshot.
- A `ce` that arrives in ACC is ignored and sets `overrun`=1. `overrun` is cleared only by `reset`.
- `busy` = (state != IDLE).

## Timing
- Reset values: `audio_l`=0, `audio_r`=0, `out_valid`=0, `busy`=0, `overrun`=0. The FSM is in IDLE, idx=0, and accumulators are 0.
- `ce` sampled at edge T: channels are added at edges T+1..T+NUM_CH.
- Outputs and `out_valid` are registered at edge T+NUM_CH+1. Latency is therefore NUM_CH+1 clocks.
- `out_valid` is high for exactly one clk after edge T+NUM_CH+1.
- The minimum accepted `ce` period is NUM_CH+1 clocks. A `ce` at edge T+NUM_CH+1 (the OUT state) is accepted and does not set `overrun`.
- `reset` mid-mix forces IDLE at the next edge with all outputs at their reset values. No `out_valid` is emitted for the aborted mix.
- `reset` and `ce` asserted together: `reset` wins, and the `ce` is discarded without setting `overrun`.

## Configuration
- `CPC_AUDIO_MIXER_SIGNED_EN` defined: after saturation, the MSB of each output is inverted. Outputs are then two's-complement with the midpoint at 0 (unsigned 0 becomes -2^(OUT_W-1)). The reset value remains 0.
- `CPC_AUDIO_MIXER_SIGNED_EN` undefined: outputs are unsigned saturated sums, as specified above.

## Test plan
- Legacy mix: NUM_CH=3, ch A/B/C = 0xFE/0xFC/0x00, legacy pans, pulse `ce`. Require `audio_l`=0xBE and `audio_r`=0x3F, with `out_valid` exactly 4 clks after `ce`, for one clk.
- Saturation: all channels 0xFF, all pans 3. Require `audio_l`=`audio_r`=0xFF (sum 765 clipped), with `overrun`=0.
- Overrun: `ce` at T and again at T+2. Require `overrun`=1, one `out_valid` only, and outputs computed from the T snapshot.
- Back-to-back: `ce` every 4 clks for 10 strobes, with `ch_in` changing after each strobe. Require 10 `out_valid` pulses, each matching its own snapshot, and `overrun`=0.
- Reset mid-mix: `ce` at T, `reset` at T+2. Require outputs 0, `busy`=0 at T+3, and no `out_valid`. A following `ce` mixes normally.
- Signed build: with `CPC_AUDIO_MIXER_SIGNED_EN` defined and all channels 0, require `audio_l`=`audio_r`=0x80. With channel A=0x80 and pan_l A=3 (other channels 0), require `audio_l`=0x00.

Source files
------------

// File: rtl/cpc_audio_mixer.sv
// cpc_audio_mixer: time-multiplexed N-channel stereo mixer.
// A ce strobe snapshots every channel sample and its left/right gain code;
// one channel is accumulated per clock, then both sums are saturated and
// presented on registered outputs with a one-cycle out_valid pulse.
// Optional build macro: CPC_AUDIO_MIXER_SIGNED_EN (outputs offset to
// two's-complement by inverting the MSB after saturation).
module cpc_audio_mixer #(
  parameter int NUM_CH = 3,
  parameter int IN_W   = 8,
  parameter int OUT_W  = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ce,
  input  logic [NUM_CH*IN_W-1:0]   ch_in,
  input  logic [NUM_CH*2-1:0]      pan_l,
  input  logic [NUM_CH*2-1:0]      pan_r,
  output logic [OUT_W-1:0]         audio_l,
  output logic [OUT_W-1:0]         audio_r,
  output logic                     out_valid,
  output logic                     busy,
  output logic                     overrun
);

  localparam int ACC_W = IN_W + $clog2(NUM_CH) + 1;
  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int EXT_W = ACC_W + OUT_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACC,
    S_OUT
  } state_t;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [ACC_W-1:0]         acc_l_q, acc_l_d;
  logic [ACC_W-1:0]         acc_r_q, acc_r_d;
  logic [NUM_CH*IN_W-1:0]   snap_ch_q, snap_ch_d;
  logic [NUM_CH*2-1:0]      snap_pl_q, snap_pl_d;
  logic [NUM_CH*2-1:0]      snap_pr_q, snap_pr_d;
  logic [OUT_W-1:0]         aud_l_q, aud_l_d;
  logic [OUT_W-1:0]         aud_r_q, aud_r_d;
  logic                     valid_q, valid_d;
  logic                     ovr_q, ovr_d;

  logic [IN_W-1:0]          cur_ch;
  logic [1:0]               cur_pl;
  logic [1:0]               cur_pr;
  logic                     take;

  // Gain code: 3 -> x, 2 -> x/2, 1 -> x/4, 0 -> muted.
  function automatic logic [IN_W-1:0] scale(input logic [IN_W-1:0] x,
                                            input logic [1:0]      g);
    logic [IN_W-1:0] r;
    case (g)
      2'd3:    r = x;
      2'd2:    r = x >> 1;
      2'd1:    r = x >> 2;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Clip an accumulator to the output range; signed builds flip the MSB
  // afterwards so the unsigned midpoint lands on zero.
  function automatic logic [OUT_W-1:0] sat(input logic [ACC_W-1:0] a);
    logic [EXT_W-1:0] e;
    logic [OUT_W-1:0] r;
    e = EXT_W'(a);
    if (e > EXT_W'({OUT_W{1'b1}})) r = '1;
    else                           r = e[OUT_W-1:0];
`ifdef CPC_AUDIO_MIXER_SIGNED_EN
    r[OUT_W-1] = ~r[OUT_W-1];
`else
    r = r;
`endif
    return r;
  endfunction

  // Select the snapshotted channel currently being accumulated.
  always_comb begin
    cur_ch = snap_ch_q[int'(idx_q)*IN_W +: IN_W];
    cur_pl = snap_pl_q[int'(idx_q)*2 +: 2];
    cur_pr = snap_pr_q[int'(idx_q)*2 +: 2];
  end

  // Next-state and datapath logic for the IDLE -> ACC -> OUT sequence.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    snap_ch_d = snap_ch_q;
    snap_pl_d = snap_pl_q;
    snap_pr_d = snap_pr_q;
    aud_l_d   = aud_l_q;
    aud_r_d   = aud_r_q;
    valid_d   = 1'b0;
    ovr_d     = ovr_q;
    take      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ce) take = 1'b1;
      end
      S_ACC: begin
        acc_l_d = acc_l_q + ACC_W'(scale(cur_ch, cur_pl));
        acc_r_d = acc_r_q + ACC_W'(scale(cur_ch, cur_pr));
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(NUM_CH - 1)) state_d = S_OUT;
        if (ce) ovr_d = 1'b1;
      end
      S_OUT: begin
        aud_l_d = sat(acc_l_q);
        aud_r_d = sat(acc_r_q);
        valid_d = 1'b1;
        // A strobe here is accepted straight away, as if from IDLE.
        if (ce) take = 1'b1;
        else    state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (take) begin
      snap_ch_d = ch_in;
      snap_pl_d = pan_l;
      snap_pr_d = pan_r;
      acc_l_d   = '0;
      acc_r_d   = '0;
      idx_d     = '0;
      state_d   = S_ACC;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      snap_ch_q <= '0;
      snap_pl_q <= '0;
      snap_pr_q <= '0;
      aud_l_q   <= '0;
      aud_r_q   <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      snap_ch_q <= snap_ch_d;
      snap_pl_q <= snap_pl_d;
      snap_pr_q <= snap_pr_d;
      aud_l_q   <= aud_l_d;
      aud_r_q   <= aud_r_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign audio_l   = aud_l_q;
  assign audio_r   = aud_r_q;
  assign out_valid = valid_q;
  assign overrun   = ovr_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_cpc_audio_mixer.sv
// Scoreboard bench for cpc_audio_mixer (NUM_CH=3, IN_W=8, OUT_W=8).
module tb_cpc_audio_mixer;

  localparam int NC = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ce = 1'b0;
  logic [23:0]   ch_in = '0;
  logic [5:0]    pan_l = '0;
  logic [5:0]    pan_r = '0;
  logic [7:0]    audio_l, audio_r;
  logic          out_valid, busy, overrun;

  cpc_audio_mixer #(.NUM_CH(3), .IN_W(8), .OUT_W(8)) dut (
    .clk(clk), .reset(reset), .ce(ce), .ch_in(ch_in),
    .pan_l(pan_l), .pan_r(pan_r), .audio_l(audio_l), .audio_r(audio_r),
    .out_valid(out_valid), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int unsigned l; int unsigned r; int due; } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int last_acc = -100;
  bit exp_ovr = 0;

  int unsigned chv [NC];
  int unsigned plv [NC];
  int unsigned prv [NC];

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int unsigned gain(input int unsigned x, input int unsigned g);
    if (g == 3) return x;
    if (g == 2) return x / 2;
    if (g == 1) return x / 4;
    return 0;
  endfunction

  function automatic int unsigned mixval(input bit left);
    int unsigned s = 0;
    for (int k = 0; k < NC; k++) s += gain(chv[k], left ? plv[k] : prv[k]);
    if (s > 255) s = 255;
`ifdef CPC_AUDIO_MIXER_SIGNED_EN
    s = s ^ 32'h80;
`endif
    return s;
  endfunction

  // Apply the TB channel/pan arrays to the DUT input buses.
  task automatic apply();
    for (int k = 0; k < NC; k++) begin
      ch_in[k*8 +: 8] = chv[k][7:0];
      pan_l[k*2 +: 2] = plv[k][1:0];
      pan_r[k*2 +: 2] = prv[k][1:0];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // One-cycle strobe; a strobe is accepted only if the previous accepted
  // one was at least NUM_CH+1 clocks earlier.
  task automatic strobe();
    exp_t e;
    apply();
    if (cyc - last_acc >= NC + 1) begin
      e.l = mixval(1'b1);
      e.r = mixval(1'b0);
      e.due = cyc + NC + 2;
      q.push_back(e);
      last_acc = cyc;
    end else begin
      exp_ovr = 1'b1;
    end
    ce = 1'b1;
    tick();
    ce = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    q.delete();
    last_acc = -100;
    exp_ovr = 1'b0;
    idle(n);
    reset = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    if (q.size() != 0) check("drain_timeout", q.size(), 0);
    idle(2);
  endtask

  task automatic rand_vec();
    for (int k = 0; k < NC; k++) begin
      chv[k] = $urandom_range(0, 255);
      plv[k] = $urandom_range(0, 3);
      prv[k] = $urandom_range(0, 3);
    end
  endtask

  // Monitor: every out_valid pulse must match the oldest pending mix.
  always @(negedge clk) begin
    if (out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("latency", cyc, e.due);
        check("audio_l", audio_l, e.l);
        check("audio_r", audio_r, e.r);
      end
    end
  end

  initial begin
    // Reset state
    do_reset(3);
    check("rst_audio_l", audio_l, 0);
    check("rst_audio_r", audio_r, 0);
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", overrun, 0);

    // Legacy mix
    chv = '{8'hFE, 8'hFC, 8'h00};
    plv = '{2, 1, 0};
    prv = '{0, 1, 2};
    strobe();
    check("busy_during_mix", busy, 1);
    drain();
    check("legacy_l_direct", audio_l, mixval(1'b1));

    // Saturation
    chv = '{255, 255, 255};
    plv = '{3, 3, 3};
    prv = '{3, 3, 3};
    strobe();
    drain();
    check("sat_overrun", overrun, 0);

    // Overrun: second strobe two clocks later is dropped
    rand_vec();
    strobe();
    idle(1);
    rand_vec();
    strobe();
    drain();
    check("overrun_set", overrun, 1);
    check("overrun_model", overrun, exp_ovr);
    do_reset(1);
    check("overrun_cleared", overrun, 0);

    // Back-to-back at the minimum period
    for (int i = 0; i < 10; i++) begin
      rand_vec();
      strobe();
      rand_vec();
      apply();
      idle(NC);
    end
    drain();
    check("b2b_overrun", overrun, 0);

    // Reset mid-mix: no valid for the aborted mix
    rand_vec();
    strobe();
    idle(1);
    reset = 1'b1;
    q.delete();
    last_acc = -100;
    tick();
    reset = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_l", audio_l, 0);
    check("midrst_r", audio_r, 0);
    idle(6);
    rand_vec();
    strobe();
    drain();

    // Reset and ce together: ce discarded
    do_reset(1);
    rand_vec();
    apply();
    reset = 1'b1;
    ce = 1'b1;
    tick();
    ce = 1'b0;
    reset = 1'b0;
    check("rstce_busy", busy, 0);
    check("rstce_overrun", overrun, 0);
    idle(6);

    // Signed-build vectors (model adapts to build)
    chv = '{0, 0, 0};
    plv = '{3, 3, 3};
    prv = '{3, 3, 3};
    strobe();
    drain();
    chv = '{8'h80, 0, 0};
    plv = '{3, 0, 0};
    prv = '{0, 0, 0};
    strobe();
    drain();

    // Random strobe spacing, including overruns and OUT-state strobes
    for (int i = 0; i < 200; i++) begin
      rand_vec();
      if ($urandom_range(0, 3) == 0) begin
        chv[0] = 255; chv[1] = 255; plv[0] = 3; plv[1] = 3;
      end
      strobe();
      idle($urandom_range(0, 6));
    end
    drain();
    check("rand_overrun", overrun, exp_ovr);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

endmodule
